// File: rtl/writeback_buffer.sv
// Posted write buffer between the cache writeback stage and main memory.
// Holds up to DEPTH evicted (address, data) entries in a circular queue and
// drains them in order through a req/ack handshake. A repeated write to a
// queued address is folded into that entry, unless that entry is the one
// currently presented to memory. Snoop lookups return the newest queued data
// for an address so that a miss fill never sees data that is older than a
// queued write.
module writeback_buffer #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DEPTH         = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wb_valid,
    input  logic [ADDRESS_WIDTH-1:0] wb_address,
    input  logic [DATA_WIDTH-1:0]    wb_data,
    output logic                     wb_ack,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     mem_req,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_data,
    input  logic                     mem_ack,
    input  logic [ADDRESS_WIDTH-1:0] snoop_address,
    output logic                     snoop_hit,
    output logic [DATA_WIDTH-1:0]    snoop_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

    state_t                   state_q, state_d;
    logic [DEPTH-1:0]         valid_q;
    logic [ADDRESS_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0]    data_q [DEPTH];
    logic [PW-1:0]            head_q, tail_q;
    logic [CW-1:0]            count_q, count_d;
    logic                     wb_ack_q, wb_ack_d;
    logic                     mem_req_q, mem_req_d;
    logic [ADDRESS_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0]    mem_data_q, mem_data_d;

    logic                     capture, merge_hit, do_merge, do_push, do_pop, latch;
    logic [PW-1:0]            merge_idx, snoop_idx;

    assign full        = (count_q == CW'(DEPTH));
    assign empty       = (count_q == '0);
    assign count       = count_q;
    assign wb_ack      = wb_ack_q;
    assign mem_req     = mem_req_q;
    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;

    // wb_ack_q gates capture so an entry still held during its ack cycle is not taken twice
    assign capture  = wb_valid & ~wb_ack_q;
    assign do_merge = capture & merge_hit;
    assign do_push  = capture & ~merge_hit & ~full;
    assign wb_ack_d = do_merge | do_push;
    assign count_d  = count_q + CW'(do_push) - CW'(do_pop);

    // Find a queued entry with the incoming address; the head in flight is excluded
    always_comb begin
        merge_hit = 1'b0;
        merge_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && addr_q[i] == wb_address &&
                !(mem_req_q && PW'(i) == head_q)) begin
                merge_hit = 1'b1;
                merge_idx = PW'(i);
            end
        end
    end

    // Snoop walks oldest to newest so the entry nearest the tail wins
    always_comb begin
        snoop_hit  = 1'b0;
        snoop_data = '0;
        snoop_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            snoop_idx = head_q + PW'(k);
            if (valid_q[snoop_idx] && addr_q[snoop_idx] == snoop_address) begin
                snoop_hit  = 1'b1;
                snoop_data = data_q[snoop_idx];
            end
        end
    end

    // Drain FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Drain FSM next state: one request, wait for ack, one idle cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty) state_d = REQ;
            REQ:     if (mem_ack) state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Drain FSM outputs: request level, head latch and pop strobes
    always_comb begin
        mem_req_d = mem_req_q;
        latch     = 1'b0;
        do_pop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    mem_req_d = 1'b1;
                    latch     = 1'b1;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    do_pop    = 1'b1;
                end
            end
            default: mem_req_d = 1'b0;
        endcase
    end

    // A merge into the head on the latch edge forwards the new data so memory sees it
    always_comb begin
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        if (latch) begin
            mem_address_d = addr_q[head_q];
            mem_data_d    = (do_merge && merge_idx == head_q) ? wb_data : data_q[head_q];
        end
    end

    // Control state: valid bits, pointers, count, handshake outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            wb_ack_q      <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
        end else begin
            if (do_pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PW'(1);
            end
            if (do_push) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PW'(1);
            end
            count_q       <= count_d;
            wb_ack_q      <= wb_ack_d;
            mem_req_q     <= mem_req_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
        end
    end

    // Entry payload storage; only meaningful where the valid bit is set
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_q[tail_q] <= wb_address;
            data_q[tail_q] <= wb_data;
        end
        if (do_merge) data_q[merge_idx] <= wb_data;
    end

endmodule

// File: tb/tb_writeback_buffer.sv
module tb_writeback_buffer;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wb_valid;
    logic [AW-1:0] wb_address;
    logic [DW-1:0] wb_data;
    logic          wb_ack, full, empty;
    logic [2:0]    count;
    logic          mem_req;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic          mem_ack;
    logic [AW-1:0] snoop_address;
    logic          snoop_hit;
    logic [DW-1:0] snoop_data;

    int checks = 0;
    int errors = 0;

    // Reference model: an ordered list of queued writes plus the drain phase
    logic [AW-1:0] mq_a[$];
    logic [DW-1:0] mq_d[$];
    bit            m_req, m_gap, m_ack;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    always #5 clk = ~clk;

    writeback_buffer #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .wb_valid(wb_valid), .wb_address(wb_address), .wb_data(wb_data), .wb_ack(wb_ack),
        .full(full), .empty(empty), .count(count),
        .mem_req(mem_req), .mem_address(mem_address), .mem_data(mem_data), .mem_ack(mem_ack),
        .snoop_address(snoop_address), .snoop_hit(snoop_hit), .snoop_data(snoop_data)
    );

    task automatic model_reset();
        mq_a.delete();
        mq_d.delete();
        m_req  = 0;
        m_gap  = 0;
        m_ack  = 0;
        m_addr = '0;
        m_data = '0;
    endtask

    // One clock edge of the buffer's rules, applied to the pre-edge inputs
    task automatic model_step();
        int  n  = mq_a.size();
        int  mi = -1;
        bit  cap, push, pop;
        cap  = wb_valid && !m_ack;
        push = 0;
        if (cap)
            for (int i = n - 1; i >= 0; i--)
                if (mi < 0 && mq_a[i] == wb_address && !(i == 0 && m_req)) mi = i;
        m_ack = 0;
        if (cap && mi >= 0) begin
            mq_d[mi] = wb_data;
            m_ack = 1;
        end else if (cap && n < DEPTH) begin
            push  = 1;
            m_ack = 1;
        end
        pop = m_req && mem_ack;
        if (!m_req && !m_gap && n > 0) begin
            m_req  = 1;
            m_addr = mq_a[0];
            m_data = mq_d[0];
        end else if (pop) begin
            void'(mq_a.pop_front());
            void'(mq_d.pop_front());
            m_req = 0;
            m_gap = 1;
        end else if (m_gap) begin
            m_gap = 0;
        end
        if (push) begin
            mq_a.push_back(wb_address);
            mq_d.push_back(wb_data);
        end
    endtask

    function automatic bit model_snoop(input logic [AW-1:0] a, output logic [DW-1:0] d);
        d = '0;
        for (int i = mq_a.size() - 1; i >= 0; i--)
            if (mq_a[i] == a) begin
                d = mq_d[i];
                return 1'b1;
            end
        return 1'b0;
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        wb_valid      = 1'b0;
        wb_address    = '0;
        wb_data       = '0;
        mem_ack       = 1'b0;
        snoop_address = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Present one entry until the model expects it accepted, then drop valid
    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb_valid   = 1'b1;
        wb_address = a;
        wb_data    = d;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (m_ack) break;
        end
        wb_valid = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        do_reset();
        checks += 9;
        if (count !== 3'd0)       begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        if (empty !== 1'b1)       begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        if (full !== 1'b0)        begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
        if (mem_req !== 1'b0)     begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
        if (wb_ack !== 1'b0)      begin errors++; $display("FAIL reset_wb_ack: got %b expected 0", wb_ack); end
        if (mem_address !== '0)   begin errors++; $display("FAIL reset_mem_address: got %h expected 0", mem_address); end
        if (mem_data !== '0)      begin errors++; $display("FAIL reset_mem_data: got %h expected 0", mem_data); end
        if (snoop_hit !== 1'b0)   begin errors++; $display("FAIL reset_snoop_hit: got %b expected 0", snoop_hit); end
        if (snoop_data !== '0)    begin errors++; $display("FAIL reset_snoop_data: got %h expected 0", snoop_data); end
    endtask

    task automatic test_single_entry();
        do_reset();
        wb_valid   = 1'b1;
        wb_address = 32'h0000_1000;
        wb_data    = 32'hDEAD_BEEF;
        cyc();
        checks += 3;
        if (wb_ack !== 1'b1)  begin errors++; $display("FAIL single_ack: got %b expected 1", wb_ack); end
        if (count !== 3'd1)   begin errors++; $display("FAIL single_count: got %0d expected 1", count); end
        if (mem_req !== 1'b0) begin errors++; $display("FAIL single_req_early: got %b expected 0", mem_req); end
        wb_valid = 1'b0;
        cyc();
        checks += 4;
        if (mem_req !== 1'b1)              begin errors++; $display("FAIL single_req: got %b expected 1", mem_req); end
        if (mem_address !== 32'h0000_1000) begin errors++; $display("FAIL single_addr: got %h expected 00001000", mem_address); end
        if (mem_data !== 32'hDEAD_BEEF)    begin errors++; $display("FAIL single_data: got %h expected deadbeef", mem_data); end
        if (wb_ack !== 1'b0)               begin errors++; $display("FAIL single_ack_low: got %b expected 0", wb_ack); end
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        checks += 3;
        if (count !== 3'd0)   begin errors++; $display("FAIL single_pop_count: got %0d expected 0", count); end
        if (empty !== 1'b1)   begin errors++; $display("FAIL single_pop_empty: got %b expected 1", empty); end
        if (mem_req !== 1'b0) begin errors++; $display("FAIL single_pop_req: got %b expected 0", mem_req); end
        cyc();
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL single_release_req: got %b expected 0", mem_req); end
    endtask

    task automatic test_fill_stall();
        logic [AW-1:0] addrs [5];
        logic [DW-1:0] datas [5];
        do_reset();
        for (int i = 0; i < 5; i++) begin
            addrs[i] = 32'h0000_2000 + 32'(i) * 32'h40;
            datas[i] = 32'hA0 + 32'(i);
        end
        for (int i = 0; i < 4; i++) push(addrs[i], datas[i]);
        checks += 4;
        if (count !== 3'd4)        begin errors++; $display("FAIL fill_count: got %0d expected 4", count); end
        if (full !== 1'b1)         begin errors++; $display("FAIL fill_full: got %b expected 1", full); end
        if (mem_req !== 1'b1)      begin errors++; $display("FAIL fill_req: got %b expected 1", mem_req); end
        if (mem_address !== addrs[0]) begin errors++; $display("FAIL fill_head: got %h expected %h", mem_address, addrs[0]); end
        wb_valid   = 1'b1;
        wb_address = addrs[4];
        wb_data    = datas[4];
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks += 2;
            if (wb_ack !== 1'b0) begin errors++; $display("FAIL stall_ack: got %b expected 0", wb_ack); end
            if (count !== 3'd4)  begin errors++; $display("FAIL stall_count: got %0d expected 4", count); end
        end
        // Pop while full: the same edge must refuse the held push
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        checks += 3;
        if (count !== 3'd3)  begin errors++; $display("FAIL popfull_count: got %0d expected 3", count); end
        if (wb_ack !== 1'b0) begin errors++; $display("FAIL popfull_ack: got %b expected 0", wb_ack); end
        if (full !== 1'b0)   begin errors++; $display("FAIL popfull_full: got %b expected 0", full); end
        cyc();
        checks += 2;
        if (wb_ack !== 1'b1) begin errors++; $display("FAIL late_push_ack: got %b expected 1", wb_ack); end
        if (count !== 3'd4)  begin errors++; $display("FAIL late_push_count: got %0d expected 4", count); end
        wb_valid = 1'b0;
        for (int i = 1; i < 5; i++) begin
            for (int t = 0; t < 10 && mem_req !== 1'b1; t++) cyc();
            checks += 2;
            if (mem_address !== addrs[i] || mem_req !== 1'b1) begin
                errors++; $display("FAIL drain_addr[%0d]: got %h req %b expected %h", i, mem_address, mem_req, addrs[i]);
            end
            if (mem_data !== datas[i]) begin errors++; $display("FAIL drain_data[%0d]: got %h expected %h", i, mem_data, datas[i]); end
            mem_ack = 1'b1;
            cyc();
            mem_ack = 1'b0;
        end
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", empty); end
    endtask

    task automatic test_merge_snoop();
        logic [AW-1:0] ea [4];
        logic [DW-1:0] ed [4];
        do_reset();
        push(32'h3000, 32'h11);
        checks += 2;
        if (mem_req !== 1'b1)          begin errors++; $display("FAIL merge_head_req: got %b expected 1", mem_req); end
        if (mem_address !== 32'h3000)  begin errors++; $display("FAIL merge_head_addr: got %h expected 3000", mem_address); end
        push(32'h3040, 32'h22);
        push(32'h3080, 32'h33);
        push(32'h3040, 32'h99);
        checks++;
        if (count !== 3'd3) begin errors++; $display("FAIL merge_count: got %0d expected 3", count); end
        push(32'h3000, 32'h55);
        checks += 2;
        if (count !== 3'd4) begin errors++; $display("FAIL head_dup_count: got %0d expected 4", count); end
        if (mem_data !== 32'h11) begin errors++; $display("FAIL head_stable_data: got %h expected 11", mem_data); end
        snoop_address = 32'h3000; #1;
        checks += 2;
        if (snoop_hit !== 1'b1)    begin errors++; $display("FAIL snoop_a_hit: got %b expected 1", snoop_hit); end
        if (snoop_data !== 32'h55) begin errors++; $display("FAIL snoop_a_data: got %h expected 55", snoop_data); end
        snoop_address = 32'h3040; #1;
        checks++;
        if (snoop_data !== 32'h99) begin errors++; $display("FAIL snoop_b_data: got %h expected 99", snoop_data); end
        snoop_address = 32'h3FC0; #1;
        checks += 2;
        if (snoop_hit !== 1'b0) begin errors++; $display("FAIL snoop_miss_hit: got %b expected 0", snoop_hit); end
        if (snoop_data !== '0)  begin errors++; $display("FAIL snoop_miss_data: got %h expected 0", snoop_data); end
        ea = '{32'h3000, 32'h3040, 32'h3080, 32'h3000};
        ed = '{32'h11, 32'h99, 32'h33, 32'h55};
        for (int i = 0; i < 4; i++) begin
            for (int t = 0; t < 10 && mem_req !== 1'b1; t++) cyc();
            checks += 2;
            if (mem_address !== ea[i] || mem_req !== 1'b1) begin
                errors++; $display("FAIL merge_drain_addr[%0d]: got %h req %b expected %h", i, mem_address, mem_req, ea[i]);
            end
            if (mem_data !== ed[i]) begin errors++; $display("FAIL merge_drain_data[%0d]: got %h expected %h", i, mem_data, ed[i]); end
            mem_ack = 1'b1;
            cyc();
            mem_ack = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push(32'h5000, 32'h1);
        push(32'h5040, 32'h2);
        wb_valid   = 1'b1;
        wb_address = 32'h5080;
        wb_data    = 32'h3;
        cyc();
        checks += 3;
        if (wb_ack !== 1'b1)  begin errors++; $display("FAIL pre_reset_ack: got %b expected 1", wb_ack); end
        if (count !== 3'd3)   begin errors++; $display("FAIL pre_reset_count: got %0d expected 3", count); end
        if (mem_req !== 1'b1) begin errors++; $display("FAIL pre_reset_req: got %b expected 1", mem_req); end
        #2;
        reset_n  = 1'b0;
        wb_valid = 1'b0;
        #1;
        model_reset();
        checks += 4;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL async_req: got %b expected 0", mem_req); end
        if (count !== 3'd0)   begin errors++; $display("FAIL async_count: got %0d expected 0", count); end
        if (wb_ack !== 1'b0)  begin errors++; $display("FAIL async_ack: got %b expected 0", wb_ack); end
        if (empty !== 1'b1)   begin errors++; $display("FAIL async_empty: got %b expected 1", empty); end
        @(negedge clk);
        reset_n = 1'b1;
        mem_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            checks += 2;
            if (mem_req !== 1'b0) begin errors++; $display("FAIL stale_req: got %b expected 0", mem_req); end
            if (count !== 3'd0)   begin errors++; $display("FAIL stale_count: got %0d expected 0", count); end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_random();
        logic [DW-1:0] sd;
        bit            sh;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if (wb_valid && m_ack) begin
                wb_valid = 1'($urandom_range(0, 1));
                wb_address = 32'h4000 + 32'($urandom_range(0, 5)) * 32'h40;
                wb_data    = $urandom;
            end else if (!wb_valid && $urandom_range(0, 2) == 0) begin
                wb_valid   = 1'b1;
                wb_address = 32'h4000 + 32'($urandom_range(0, 5)) * 32'h40;
                wb_data    = $urandom;
            end
            mem_ack       = 1'($urandom_range(0, 1));
            snoop_address = 32'h4000 + 32'($urandom_range(0, 6)) * 32'h40;
            cyc();
            sh = model_snoop(snoop_address, sd);
            checks += 7;
            if (wb_ack !== m_ack)   begin errors++; $display("FAIL rnd_ack @%0d: got %b expected %b", n, wb_ack, m_ack); end
            if (count !== 3'(mq_a.size())) begin errors++; $display("FAIL rnd_count @%0d: got %0d expected %0d", n, count, mq_a.size()); end
            if (full !== (mq_a.size() == DEPTH)) begin errors++; $display("FAIL rnd_full @%0d: got %b", n, full); end
            if (empty !== (mq_a.size() == 0))    begin errors++; $display("FAIL rnd_empty @%0d: got %b", n, empty); end
            if (mem_req !== m_req)  begin errors++; $display("FAIL rnd_req @%0d: got %b expected %b", n, mem_req, m_req); end
            if (snoop_hit !== sh)   begin errors++; $display("FAIL rnd_snoop_hit @%0d: got %b expected %b", n, snoop_hit, sh); end
            if (snoop_data !== sd)  begin errors++; $display("FAIL rnd_snoop_data @%0d: got %h expected %h", n, snoop_data, sd); end
            if (m_req) begin
                checks += 2;
                if (mem_address !== m_addr) begin errors++; $display("FAIL rnd_addr @%0d: got %h expected %h", n, mem_address, m_addr); end
                if (mem_data !== m_data)    begin errors++; $display("FAIL rnd_data @%0d: got %h expected %h", n, mem_data, m_data); end
            end
        end
        wb_valid = 1'b0;
        mem_ack  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_entry();
        test_fill_stall();
        test_merge_snoop();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/writeback_buffer.md
Name: writeback_buffer

Overview:
- Posted write buffer between the cache writeback stage and main memory.
- Captures evicted (address, data) entries through a strobe/ack handshake, queues up to DEPTH of them, and drains them in order to memory through a req/ack handshake.
- Merges a repeated write to an address already queued into that entry.
- Serves snoop lookups so that a miss fill never reads memory data that is older than a queued write.

Parameters:
DATA_WIDTH, 32, width of one writeback data word
ADDRESS_WIDTH, 32, width of a block-aligned write address
DEPTH, 4, number of entries; power of two, at least 2

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
wb_valid  in  1  writeback stage presents an entry; held until wb_ack is seen
wb_address  in  ADDRESS_WIDTH  address of the presented entry
wb_data  in  DATA_WIDTH  data of the presented entry
wb_ack  out  1  one-cycle pulse: entry accepted (pushed or merged)
full  out  1  count == DEPTH
empty  out  1  count == 0
count  out  $clog2(DEPTH)+1  number of valid entries
mem_req  out  1  write request to memory
mem_address  out  ADDRESS_WIDTH  head entry address; stable while mem_req=1
mem_data  out  DATA_WIDTH  head entry data; stable while mem_req=1
mem_ack  in  1  memory accepted the head write (already synchronised)
snoop_address  in  ADDRESS_WIDTH  address from the miss-fill path
snoop_hit  out  1  some valid entry matches snoop_address (combinational)
snoop_data  out  DATA_WIDTH  data of the newest matching entry; 0 when there is no hit

Behaviour:
- Reset (asynchronous): all valid bits cleared, pointers 0, count 0, wb_ack=0, mem_req=0, mem_address/mem_data=0, drain FSM in IDLE. Queued entries are discarded. Reset mid-handshake drops mem_req immediately.
- Storage: circular array of DEPTH entries with head and tail pointers. Pointers wrap modulo DEPTH. count is kept as a separate register.
- Accept: evaluated at a clock edge where wb_valid=1 and wb_ack=0.
  - Merge: if wb_address equals a valid entry's address and that entry is not the head while mem_req=1, that entry's data is overwritten. count is unchanged. Merge is allowed when full=1.
  - Push: otherwise, if full=0, the entry is written at the tail, tail advances, count increments.
  - Stall: otherwise (full=1, no merge) nothing happens and no ack is issued.
  - Latency: wb_ack=1 in the cycle after the capture edge, then 0 for at least one cycle. The wb_ack=0 condition prevents a double capture while upstream is still dropping wb_valid.
- Drain FSM:
  - IDLE: if empty=0, go to REQ. mem_req<=1 and the head entry is latched into mem_address/mem_data.
  - REQ: hold mem_req and the outputs stable. When mem_ack=1 is sampled: pop the head (valid cleared, head advances, count decrements), mem_req<=0, go to RELEASE.
  - RELEASE: one cycle with mem_req=0, then go to IDLE.
  - Minimum spacing is therefore 3 cycles per drained entry.
- mem_ack sampled in IDLE or RELEASE is ignored.
- Push and pop at the same edge: count unchanged, both pointers advance. The full decision uses the pre-edge count, so a push is refused at the edge where a full buffer pops.
- Merge never targets the entry currently latched in mem_address/mem_data. A write to that address is pushed as a new entry instead.
- Snoop:
  - Compare against all valid entries, including the head in flight.
  - On multiple matches (at most two, since a merge blocker creates a duplicate), the entry nearest the tail wins.
  - A snoop in the same cycle as a push does not see the incoming entry.
- Width rules: count ranges 0..DEPTH. Pointers are $clog2(DEPTH) bits and wrap naturally.

Test Plan:
- Single entry: push 0x0000_1000/0xDEADBEEF on an idle buffer → wb_ack at cycle+1, count=1, mem_req rises next cycle with the same address/data. After mem_ack → count=0, empty=1, mem_req=0 for one cycle.
- Fill and stall: push 5 distinct addresses with mem_ack held 0 → first 4 acked, full=1, 5th gets no wb_ack. Pulse mem_ack → after the pop, the 5th is accepted and count returns to 4. Drain order equals push order (including pointer wrap).
- Merge: queue A/0x11, B/0x22, C/0x33 with head A in REQ. Write B/0x99 → count stays 3, B drains with 0x99. Write A/0x55 → pushed as a new entry, count=4.
- Snoop: after the merge scenario, snoop A → hit with data 0x55 (the newer entry). Snoop an unqueued address → hit=0, data=0.
- Simultaneous push/pop at count=4 in REQ with mem_ack=1 → pop occurs, push refused that edge and accepted on the next qualifying edge.
- Reset asserted while mem_req=1 with count=3 → mem_req, count and wb_ack are 0 immediately. After release, no stale entry drains.
